// File: rtl/blinker_sysid_checker.sv
// Avalon-MM master that reads the system-ID slave (ID, timestamp),
// compares both words with build-time values and drives a status LED.
module blinker_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'd4919,
    parameter logic [31:0] EXPECTED_TS    = 32'd1462918572,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned BLINK_BITS     = 24,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic        led
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_ID  = 2'd1,
        RD_TS  = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t                  state_q, state_d;
    logic [15:0]             timer_q, timer_d;
    logic                    id_ok_q, id_ok_d;
    logic                    ts_ok_q, ts_ok_d;
    logic                    tmo_q, tmo_d;
    logic                    auto_q, auto_d;
    logic [BLINK_BITS-1:0]   blink_q;

    // State, flags, stall timer and pending auto-start register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            id_ok_q <= 1'b0;
            ts_ok_q <= 1'b0;
            tmo_q   <= 1'b0;
            auto_q  <= AUTO_START;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            id_ok_q <= id_ok_d;
            ts_ok_q <= ts_ok_d;
            tmo_q   <= tmo_d;
            auto_q  <= auto_d;
        end
    end

    // Free-running blink divider
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            blink_q <= '0;
        end else begin
            blink_q <= blink_q + 1'b1;
        end
    end

    // Next-state logic: one read per word, abort on stall timeout
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        id_ok_d = id_ok_q;
        ts_ok_d = ts_ok_q;
        tmo_d   = tmo_q;
        auto_d  = auto_q;
        unique case (state_q)
            IDLE: begin
                timer_d = '0;
                if (start || auto_q) begin
                    state_d = RD_ID;
                    auto_d  = 1'b0;
                    id_ok_d = 1'b0;
                    ts_ok_d = 1'b0;
                    tmo_d   = 1'b0;
                end
            end
            RD_ID: begin
                if (!avm_waitrequest) begin
                    id_ok_d = (avm_readdata == EXPECTED_ID);
                    timer_d = '0;
                    state_d = RD_TS;
                end else if (timer_q == TMO_LAST) begin
                    tmo_d   = 1'b1;
                    timer_d = '0;
                    state_d = FINISH;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            RD_TS: begin
                if (!avm_waitrequest) begin
                    ts_ok_d = (avm_readdata == EXPECTED_TS);
                    timer_d = '0;
                    state_d = FINISH;
                end else if (timer_q == TMO_LAST) begin
                    tmo_d   = 1'b1;
                    timer_d = '0;
                    state_d = FINISH;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from state so reset clears them at once
    always_comb begin
        avm_read    = (state_q == RD_ID) || (state_q == RD_TS);
        avm_address = (state_q == RD_TS);
        busy        = (state_q != IDLE);
        done        = (state_q == FINISH);
        id_ok       = id_ok_q;
        ts_ok       = ts_ok_q;
        timeout     = tmo_q;
    end

    // LED: dark while checking, steady on pass, fast blink on timeout
    always_comb begin
        led = blink_q[BLINK_BITS-1];
        if (busy) begin
            led = 1'b0;
        end else if (id_ok_q && ts_ok_q) begin
            led = 1'b1;
        end else if (tmo_q) begin
            led = blink_q[BLINK_BITS-3];
        end
    end

endmodule

// File: tb/tb_blinker_sysid_checker.sv
// Directed bench for blinker_sysid_checker with a small Avalon
// slave model, protocol monitor and randomized stall regression.
module tb_blinker_sysid_checker;

    localparam logic [31:0] EXP_ID = 32'd4919;
    localparam logic [31:0] EXP_TS = 32'd1462918572;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic        avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic        busy;
    logic        done;
    logic        id_ok;
    logic        ts_ok;
    logic        timeout;
    logic        led;

    blinker_sysid_checker #(
        .EXPECTED_ID    (EXP_ID),
        .EXPECTED_TS    (EXP_TS),
        .TIMEOUT_CYCLES (10),
        .BLINK_BITS     (4),
        .AUTO_START     (1'b1)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .start           (start),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest),
        .busy            (busy),
        .done            (done),
        .id_ok           (id_ok),
        .ts_ok           (ts_ok),
        .timeout         (timeout),
        .led             (led)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [31:0] id_word;
    logic [31:0] ts_word;
    int          stall_id;
    int          stall_ts;
    bit          stuck;
    int          scnt;
    logic [3:0]  cyc;
    bit          acc_addr[$];
    int          done_cnt;
    int          viol;
    bit          prev_rw;
    bit          prev_addr;
    int          n_assert;
    int          n_fail;

    // Slave: stalls a programmable number of cycles per word
    assign avm_readdata    = avm_address ? ts_word : id_word;
    assign avm_waitrequest = stuck ||
        (scnt < (avm_address ? stall_ts : stall_id));

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) scnt <= 0;
        else if (avm_read && avm_waitrequest) scnt <= scnt + 1;
        else scnt <= 0;
    end

    // Reference blink counter
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) cyc <= '0;
        else cyc <= cyc + 4'd1;
    end

    // Record accepted read addresses
    always @(posedge clock) begin
        if (reset_n && avm_read && !avm_waitrequest)
            acc_addr.push_back(avm_address);
    end

    // Done counter and Avalon stability monitor
    always @(negedge clock) begin
        if (!reset_n) begin
            prev_rw <= 1'b0;
        end else begin
            if (done) done_cnt <= done_cnt + 1;
            if (prev_rw && avm_read && avm_address != prev_addr)
                viol <= viol + 1;
            if (prev_rw && !avm_read && !timeout)
                viol <= viol + 1;
            prev_rw   <= avm_read && avm_waitrequest;
            prev_addr <= avm_address;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    initial begin
        int d0;
        int w;
        bit id_good;
        bit ts_good;
        bit e_to;
        bit e_id;
        bit e_ts;
        n_assert = 0;
        n_fail   = 0;
        done_cnt = 0;
        viol     = 0;
        reset_n  = 1'b0;
        start    = 1'b0;
        id_word  = EXP_ID;
        ts_word  = EXP_TS;
        stall_id = 0;
        stall_ts = 0;
        stuck    = 1'b0;

        // Reset state, then auto-start check with zero-wait slave
        tick(2);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_read", avm_read, 0);
        chk("rst_addr", avm_address, 0);
        chk("rst_flags", {id_ok, ts_ok, timeout}, 0);
        chk("rst_led", led, 0);
        reset_n = 1'b1;
        tick(1);
        chk("auto_busy", busy, 1);
        chk("auto_rd_id", {avm_read, avm_address}, 2'b10);
        tick(1);
        chk("auto_rd_ts", {avm_read, avm_address}, 2'b11);
        tick(1);
        chk("auto_done", done, 1);
        chk("auto_flags", {id_ok, ts_ok, timeout}, 3'b110);
        chk("auto_led_busy", led, 0);
        tick(1);
        chk("auto_done_low", {done, busy}, 0);
        chk("auto_led_on", led, 1);
        chk("acc_count", acc_addr.size(), 2);
        chk("acc_addr0", acc_addr[0], 0);
        chk("acc_addr1", acc_addr[1], 1);

        // Timestamp mismatch: slow blink
        ts_word = 32'h0;
        pulse_start();
        tick(2);
        chk("ts_bad_done", done, 1);
        chk("ts_bad_flags", {id_ok, ts_ok, timeout}, 3'b100);
        tick(1);
        for (int i = 0; i < 10; i++) begin
            chk("slow_led", led, cyc[3]);
            tick(1);
        end
        ts_word = EXP_TS;

        // Three stall cycles per read
        stall_id = 3;
        stall_ts = 3;
        pulse_start();
        for (int k = 1; k <= 8; k++) begin
            chk("stall_rd", {avm_read, avm_address},
                {1'b1, (k > 4) ? 1'b1 : 1'b0});
            tick(1);
        end
        chk("stall_done", done, 1);
        chk("stall_flags", {id_ok, ts_ok, timeout}, 3'b110);
        tick(1);
        stall_id = 0;
        stall_ts = 0;

        // Stuck waitrequest: timeout after 10 stalled cycles
        stuck = 1'b1;
        pulse_start();
        tick(9);
        chk("tmo_still_rd", {avm_read, busy, done}, 3'b110);
        tick(1);
        chk("tmo_done", {done, avm_read}, 2'b10);
        chk("tmo_flags", {id_ok, ts_ok, timeout}, 3'b001);
        tick(1);
        chk("fast_led0", led, cyc[1]);
        tick(1);
        chk("fast_led1", led, cyc[1]);
        tick(1);
        chk("fast_led2", led, cyc[1]);
        stuck = 1'b0;
        tick(1);

        // Start while busy and on FINISH is ignored
        d0 = done_cnt;
        pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(1);
        chk("fin_state", done, 1);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("no_restart", busy, 0);
        tick(4);
        chk("still_idle", busy, 0);
        chk("one_done", done_cnt, d0 + 1);

        // Start right after done clears previous flags
        pulse_start();
        tick(2);
        chk("pre_done", done, 1);
        chk("pre_flags", {id_ok, ts_ok}, 2'b11);
        tick(1);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("new_busy", busy, 1);
        chk("new_cleared", {id_ok, ts_ok, timeout}, 0);
        tick(2);
        chk("new_done", done, 1);
        chk("new_flags", {id_ok, ts_ok}, 2'b11);
        chk("done_total", done_cnt, d0 + 3);
        tick(1);

        // Reset while stalled in the timestamp read
        stall_id = 5;
        stall_ts = 5;
        pulse_start();
        tick(7);
        chk("mid_rd_ts", {avm_read, avm_address, avm_waitrequest},
            3'b111);
        d0 = done_cnt;
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_outs",
            {avm_read, avm_address, busy, done,
             id_ok, ts_ok, timeout, led}, 0);
        tick(2);
        stall_id = 0;
        stall_ts = 0;
        reset_n = 1'b1;
        tick(1);
        chk("rerun_rd_id", {busy, avm_read, avm_address}, 3'b110);
        tick(2);
        chk("rerun_done", done, 1);
        chk("rerun_flags", {id_ok, ts_ok, timeout}, 3'b110);
        chk("no_abort_done", done_cnt, d0 + 1);
        tick(1);

        // Random stalls and data against reference model
        for (int n = 0; n < 1000; n++) begin
            stall_id = $urandom_range(0, 12);
            stall_ts = $urandom_range(0, 12);
            id_good  = 1'($urandom_range(0, 1));
            ts_good  = 1'($urandom_range(0, 1));
            id_word  = id_good ? EXP_ID
                       : EXP_ID ^ (32'h1 << $urandom_range(0, 31));
            ts_word  = ts_good ? EXP_TS
                       : EXP_TS ^ (32'h1 << $urandom_range(0, 31));
            e_to = (stall_id >= 10) || (stall_ts >= 10);
            e_id = (stall_id < 10) && id_good;
            e_ts = (stall_id < 10) && (stall_ts < 10) && ts_good;
            pulse_start();
            w = 0;
            while (!done && w < 40) begin
                tick(1);
                w++;
            end
            chk("rnd_done", done, 1);
            chk("rnd_flags", {id_ok, ts_ok, timeout}, {e_id, e_ts, e_to});
            tick(1);
        end
        chk("protocol_viol", viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
